rom_text_decoder: RTL and testbench

Sequential reader placed directly downstream of the 32-bit program ROM. On `start`, it fetches a three-word header from the ROM: opcode, operand and stop character. It then walks the data words from `DATA_BASE` upward, decodes the low byte of each word with the selected operation, and streams the decoded characters over a valid/ready interface. Streaming ends when a decoded byte equals the stop character or when the last ROM address has been consumed.

---
 rtl/rom_text_decoder_pkg.sv | 28 ++
 rtl/rom_text_decoder_if.sv | 31 +++
 rtl/rom_text_decoder_char_decode.sv | 29 ++
 rtl/rom_text_decoder.sv | 124 ++++++++++++
 tb/tb_rom_text_decoder.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_text_decoder_pkg.sv
// ----------------------------------------------------------------------------
// rom_decoder_pkg
// Shared definitions for the ROM text decoder: FSM state encoding, opcode
// values found in the header word, and the fixed header word addresses.
// ----------------------------------------------------------------------------
package rom_decoder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_OP,
        S_LD_ARG,
        S_LD_STOP,
        S_FETCH,
        S_EMIT,
        S_FIN
    } state_t;

    localparam logic [1:0] OP_XOR = 2'd1;
    localparam logic [1:0] OP_NOT = 2'd2;
    localparam logic [1:0] OP_ADD = 2'd3;

    localparam logic [10:0] HDR_OP   = 11'h000;
    localparam logic [10:0] HDR_ARG  = 11'h004;
    localparam logic [10:0] HDR_STOP = 11'h008;

    localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/rom_text_decoder_if.sv
// ----------------------------------------------------------------------------
// rom_text_decoder_if
// Bundles the ROM read port, the character stream handshake and the status
// outputs of the decoder.
//   master : decoder side (drives rom_addr, char_*, busy, done, err, count)
//   slave  : environment side (drives start, rom_data, char_ready)
// ----------------------------------------------------------------------------
interface rom_text_decoder_if #(
    parameter int ADDR_W = 11
);
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic [7:0]        char_data;
    logic              char_valid;
    logic              char_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [9:0]        char_count;

    modport master (
        input  start, rom_data, char_ready,
        output rom_addr, char_data, char_valid, busy, done, err, char_count
    );

    modport slave (
        output start, rom_data, char_ready,
        input  rom_addr, char_data, char_valid, busy, done, err, char_count
    );
endinterface

// File: rtl/rom_text_decoder_char_decode.sv
// ----------------------------------------------------------------------------
// char_decode
// Purely combinational byte decoder.
//   op   : operation selected by the header (XOR / NOT / ADD)
//   arg  : operand byte from the header
//   din  : raw data byte (low byte of the ROM word)
//   dec  : decoded character
// ----------------------------------------------------------------------------
module char_decode
    import rom_decoder_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] arg,
    input  logic [7:0] din,
    output logic [7:0] dec
);

    always_comb begin
        dec = din;
        case (op)
            OP_XOR:  dec = din ^ arg;
            OP_NOT:  dec = ~din;
            // 8-bit sum, carry out is dropped on purpose
            OP_ADD:  dec = din + arg;
            default: dec = din;
        endcase
    end

endmodule

// File: rtl/rom_text_decoder.sv
// ----------------------------------------------------------------------------
// rom_text_decoder
// Reads a three-word header (opcode, operand, stop character) from the
// program ROM, then walks the data words from DATA_BASE upward, decoding the
// low byte of each word and streaming the characters over valid/ready.
// A run ends when a decoded byte equals the stop character (not emitted) or
// after the word at LAST_ADDR has been handed off.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : master side of rom_text_decoder_if (start, ROM port, char
//            stream, busy/done/err status, char_count)
// ----------------------------------------------------------------------------
module rom_text_decoder
    import rom_decoder_pkg::*;
#(
    parameter int                ADDR_W    = 11,
    parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'('h00C),
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'('h7FC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rom_text_decoder_if.master    bus
);

    state_t     state;
    logic [1:0] op;
    logic [7:0] arg;
    logic [7:0] stop_ch;
    logic [7:0] dec;

    // Count stays pinned at its maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    char_decode u_char_decode (
        .op  (op),
        .arg (arg),
        .din (bus.rom_data[7:0]),
        .dec (dec)
    );

    assign bus.busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            op             <= '0;
            arg            <= '0;
            stop_ch        <= '0;
            bus.rom_addr   <= '0;
            bus.char_data  <= '0;
            bus.char_valid <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.char_count <= '0;
        end else begin
            // done is only ever raised on the edge entering FIN
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state          <= S_LD_OP;
                        bus.rom_addr   <= ADDR_W'(HDR_OP);
                        bus.err        <= 1'b0;
                        bus.char_count <= '0;
                    end
                end
                S_LD_OP: begin
                    // Opcode word must be exactly 1, 2 or 3
                    if (bus.rom_data[31:2] == '0 && bus.rom_data[1:0] != 2'b00) begin
                        op           <= bus.rom_data[1:0];
                        bus.rom_addr <= ADDR_W'(HDR_ARG);
                        state        <= S_LD_ARG;
                    end else begin
                        bus.err <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_LD_ARG: begin
                    arg          <= bus.rom_data[7:0];
                    bus.rom_addr <= ADDR_W'(HDR_STOP);
                    state        <= S_LD_STOP;
                end
                S_LD_STOP: begin
                    stop_ch      <= bus.rom_data[7:0];
                    bus.rom_addr <= DATA_BASE;
                    state        <= S_FETCH;
                end
                S_FETCH: begin
                    if (dec == stop_ch) begin
                        bus.done <= 1'b1;
                        state    <= S_FIN;
                    end else begin
                        bus.char_data  <= dec;
                        bus.char_valid <= 1'b1;
                        state          <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (bus.char_ready) begin
                        bus.char_valid <= 1'b0;
                        bus.char_count <= sat_inc(bus.char_count);
                        if (bus.rom_addr == LAST_ADDR) begin
                            bus.done <= 1'b1;
                            state    <= S_FIN;
                        end else begin
                            bus.rom_addr <= bus.rom_addr + ADDR_W'(4);
                            state        <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_text_decoder.sv
// ----------------------------------------------------------------------------
// tb_rom_text_decoder
// Drives ROM images into rom_text_decoder and compares the character stream
// and status against a reference model computed directly from the ROM array.
// ----------------------------------------------------------------------------
module tb_rom_text_decoder;

    logic clk;
    logic rst_n;
    logic [31:0] rom [512];

    rom_text_decoder_if #(.ADDR_W(11)) bus ();

    rom_text_decoder #(
        .ADDR_W    (11),
        .DATA_BASE (11'h00C),
        .LAST_ADDR (11'h7FC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    assign bus.rom_data = rom[bus.rom_addr[10:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // results of the last run
    logic [7:0] got [$];
    int         done_cnt;
    int         first_vld;
    int         done_cyc;
    int         end_cyc;
    bit         timed_out;

    // reference model results
    logic [7:0]  exp_q [$];
    int          exp_cnt;
    logic [10:0] exp_addr;
    bit          exp_err;

    function automatic void model_run();
        logic [7:0] a, s, b, d;
        int op;
        exp_q.delete();
        exp_err  = 0;
        exp_addr = 11'h000;
        exp_cnt  = 0;
        if (rom[0] > 32'd3 || rom[0] == 32'd0) begin
            exp_err = 1;
            return;
        end
        op = int'(rom[0]);
        a  = rom[1][7:0];
        s  = rom[2][7:0];
        for (int w = 3; w < 512; w++) begin
            b = rom[w][7:0];
            if (op == 1)      d = b ^ a;
            else if (op == 2) d = 8'(255 - int'(b));
            else              d = 8'((int'(b) + int'(a)) % 256);
            exp_addr = 11'(w * 4);
            if (d == s) break;
            exp_q.push_back(d);
        end
        exp_cnt = (exp_q.size() > 1023) ? 1023 : exp_q.size();
    endfunction

    // Pulse start, then collect handshakes until the decoder returns to idle.
    task automatic run_decode(input bit rand_ready, input int max_cyc);
        got.delete();
        done_cnt  = 0;
        first_vld = -1;
        done_cyc  = -1;
        end_cyc   = -1;
        timed_out = 1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            bus.char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.char_valid && first_vld < 0) first_vld = c;
            if (bus.done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (bus.char_valid && bus.char_ready) got.push_back(bus.char_data);
            if (!bus.busy) begin
                timed_out = 0;
                end_cyc   = c;
                break;
            end
            @(negedge clk);
        end
        bus.char_ready = 1'b0;
    endtask

    task automatic fill_random_excluding(input logic [1:0] op, input logic [7:0] a,
                                         input logic [7:0] s);
        logic [7:0] d;
        for (int w = 3; w < 512; w++) begin
            rom[w] = $urandom;
            d = (op == 2'd1) ? (rom[w][7:0] ^ a) :
                (op == 2'd2) ? ~rom[w][7:0] : (rom[w][7:0] + a);
            if (d == s) rom[w][0] = ~rom[w][0];
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b err=%b, expected 0 0 0",
                     bus.busy, bus.done, bus.err);
        end
        checks++;
        if (bus.char_valid !== 1'b0 || bus.char_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_char: valid=%b data=%h, expected 0 00",
                     bus.char_valid, bus.char_data);
        end
        checks++;
        if (bus.rom_addr !== 11'h000 || bus.char_count !== 10'd0) begin
            errors++;
            $display("FAIL reset_addr_count: addr=%h count=%0d, expected 000 0",
                     bus.rom_addr, bus.char_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.char_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b valid=%b, expected 0 0",
                     bus.busy, bus.char_valid);
        end
    endtask

    task automatic test_production;
        bit mm;
        rom[0] = 32'h2;
        rom[1] = $urandom;
        rom[2] = 32'h26;
        fill_random_excluding(2'd2, 8'h00, 8'h26);
        rom[3]  = 32'h5E;
        rom[4]  = 32'hA8;
        rom[5]  = 32'h9A;
        rom[26] = 32'hD9;
        model_run();
        run_decode(1'b0, 200);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL prod_timeout: run did not end within budget");
        end
        checks++;
        if (got.size() < 3 || got[0] !== 8'hA1 || got[1] !== 8'h57 || got[2] !== 8'h65) begin
            errors++;
            $display("FAIL prod_first_chars: got %0d chars, expected A1 57 65 first", got.size());
        end
        mm = (got.size() != exp_q.size());
        if (!mm) foreach (got[i]) if (got[i] !== exp_q[i]) mm = 1;
        checks++;
        if (mm || got.size() != 23) begin
            errors++;
            $display("FAIL prod_stream: got %0d chars, expected %0d (23) with model content",
                     got.size(), exp_q.size());
        end
        checks++;
        if (bus.char_count !== 10'd23 || bus.rom_addr !== 11'h068) begin
            errors++;
            $display("FAIL prod_final: count=%0d addr=%h, expected 23 068",
                     bus.char_count, bus.rom_addr);
        end
        checks++;
        if (done_cnt != 1 || first_vld != 5 || done_cyc != 5 + 2 * 23) begin
            errors++;
            $display("FAIL prod_timing: done_cnt=%0d first_vld=%0d done_cyc=%0d, expected 1 5 51",
                     done_cnt, first_vld, done_cyc);
        end
    endtask

    task automatic test_xor;
        rom[0] = 32'h1;
        rom[1] = 32'h07;
        rom[2] = 32'h26;
        rom[3] = 32'h6F;
        rom[4] = 32'h21;
        run_decode(1'b0, 100);
        checks++;
        if (timed_out || got.size() != 1 || got[0] !== 8'h68) begin
            errors++;
            $display("FAIL xor_stream: timeout=%0d chars=%0d first=%h, expected 0 1 68",
                     timed_out, got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
        checks++;
        if (bus.char_count !== 10'd1 || bus.rom_addr !== 11'h010 || done_cnt != 1) begin
            errors++;
            $display("FAIL xor_final: count=%0d addr=%h done=%0d, expected 1 010 1",
                     bus.char_count, bus.rom_addr, done_cnt);
        end
    endtask

    task automatic test_add_wrap;
        rom[0] = 32'h3;
        rom[1] = 32'h10;
        rom[2] = 32'h00;
        rom[3] = 32'hABCD_12F8;
        rom[4] = 32'hF0;
        run_decode(1'b0, 100);
        checks++;
        if (timed_out || got.size() != 1 || got[0] !== 8'h08) begin
            errors++;
            $display("FAIL add_wrap: timeout=%0d chars=%0d first=%h, expected 0 1 08",
                     timed_out, got.size(), (got.size() > 0) ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0]  d0;
        logic [10:0] a0;
        logic [9:0]  c0;
        bit stable;
        bit seen;
        rom[0] = 32'h2;
        rom[1] = 32'h0;
        rom[2] = 32'h26;
        fill_random_excluding(2'd2, 8'h00, 8'h26);
        model_run();
        bus.char_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.char_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL bp_valid: char_valid=0 after 20 cycles, expected 1");
        end
        d0 = bus.char_data;
        a0 = bus.rom_addr;
        c0 = bus.char_count;
        stable = 1;
        repeat (5) begin
            @(negedge clk);
            if (bus.char_valid !== 1'b1 || bus.char_data !== d0 ||
                bus.rom_addr !== a0 || bus.char_count !== c0) stable = 0;
        end
        checks++;
        if (!stable || d0 !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_hold: stable=%0d data=%h, expected 1 %h", stable, d0, exp_q[0]);
        end
        bus.char_ready = 1'b1;
        @(negedge clk);
        bus.char_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.char_count !== c0 + 10'd1 || bus.char_data !== exp_q[1]) begin
            errors++;
            $display("FAIL bp_release: count=%0d data=%h, expected %0d %h",
                     bus.char_count, bus.char_data, c0 + 10'd1, exp_q[1]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_invalid;
        rom[0] = 32'h0;
        run_decode(1'b0, 20);
        checks++;
        if (timed_out || bus.err !== 1'b1 || first_vld != -1 || done_cnt != 0 || end_cyc != 2) begin
            errors++;
            $display("FAIL invalid_zero: err=%b vld_cyc=%0d done=%0d end=%0d, expected 1 -1 0 2",
                     bus.err, first_vld, done_cnt, end_cyc);
        end
        rom[0] = 32'h0000_0101;
        run_decode(1'b0, 20);
        checks++;
        if (bus.err !== 1'b1 || got.size() != 0 || done_cnt != 0) begin
            errors++;
            $display("FAIL invalid_high: err=%b chars=%0d done=%0d, expected 1 0 0",
                     bus.err, got.size(), done_cnt);
        end
        rom[0] = 32'h1;
        rom[1] = 32'h07;
        rom[2] = 32'h26;
        rom[3] = 32'h21;
        run_decode(1'b0, 20);
        checks++;
        if (bus.err !== 1'b0 || done_cnt != 1 || got.size() != 0) begin
            errors++;
            $display("FAIL invalid_clear: err=%b done=%0d chars=%0d, expected 0 1 0",
                     bus.err, done_cnt, got.size());
        end
    endtask

    task automatic test_no_stop;
        logic [7:0] a;
        bit mm;
        a = 8'($urandom);
        rom[0] = 32'h1;
        rom[1] = {24'h0, a};
        rom[2] = 32'h26;
        fill_random_excluding(2'd1, a, 8'h26);
        model_run();
        run_decode(1'b0, 2000);
        mm = (got.size() != exp_q.size());
        if (!mm) foreach (got[i]) if (got[i] !== exp_q[i]) mm = 1;
        checks++;
        if (timed_out || mm) begin
            errors++;
            $display("FAIL nostop_stream: timeout=%0d chars=%0d, expected 0 %0d",
                     timed_out, got.size(), exp_q.size());
        end
        checks++;
        if (bus.char_count !== 10'(exp_cnt) || bus.rom_addr !== 11'h7FC ||
            done_cnt != 1 || done_cyc != 4 + 2 * exp_cnt) begin
            errors++;
            $display("FAIL nostop_final: count=%0d addr=%h done=%0d cyc=%0d, expected %0d 7fc 1 %0d",
                     bus.char_count, bus.rom_addr, done_cnt, done_cyc, exp_cnt, 4 + 2 * exp_cnt);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        bit quiet;
        rom[0] = 32'h1;
        rom[1] = 32'h0;
        rom[2] = 32'h26;
        fill_random_excluding(2'd1, 8'h00, 8'h26);
        bus.char_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.char_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || bus.char_valid !== 1'b0 || bus.busy !== 1'b0 || bus.char_data !== 8'h00 ||
            bus.rom_addr !== 11'h000 || bus.char_count !== 10'd0 || bus.done !== 1'b0 ||
            bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: seen=%0d valid=%b busy=%b data=%h addr=%h count=%0d, expected 1 0 0 00 000 0",
                     seen, bus.char_valid, bus.busy, bus.char_data, bus.rom_addr, bus.char_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.char_valid !== 1'b0) quiet = 0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL reset_mid_after: activity seen after aborted run, expected none");
        end
    endtask

    task automatic test_random;
        bit mm;
        logic [1:0] op;
        for (int it = 0; it < 6; it++) begin
            op = 2'($urandom_range(0, 3));
            rom[0] = (it == 5) ? $urandom : {30'h0, op};
            rom[1] = $urandom;
            rom[2] = $urandom;
            for (int w = 3; w < 512; w++) rom[w] = $urandom;
            model_run();
            run_decode(1'b1, 5000);
            mm = (got.size() != exp_q.size());
            if (!mm) foreach (got[i]) if (got[i] !== exp_q[i]) mm = 1;
            checks++;
            if (timed_out || mm) begin
                errors++;
                $display("FAIL random_stream[%0d]: timeout=%0d chars=%0d, expected 0 %0d",
                         it, timed_out, got.size(), exp_q.size());
            end
            checks++;
            if (bus.err !== exp_err || bus.char_count !== 10'(exp_cnt) ||
                bus.rom_addr !== exp_addr || done_cnt != (exp_err ? 0 : 1)) begin
                errors++;
                $display("FAIL random_final[%0d]: err=%b count=%0d addr=%h done=%0d, expected %0d %0d %h %0d",
                         it, bus.err, bus.char_count, bus.rom_addr, done_cnt,
                         exp_err, exp_cnt, exp_addr, exp_err ? 0 : 1);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.char_ready = 1'b0;
        for (int w = 0; w < 512; w++) rom[w] = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_production();
        test_xor();
        test_add_wrap();
        test_backpressure();
        test_invalid();
        test_no_stop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
